// File: rtl/round_sequencer_pkg.sv
// Shared types and defaults for the round sequencer and its frame divider.
package round_sequencer_pkg;

  localparam int unsigned SEC_W   = 4;
  localparam int unsigned ROUND_W = 3;

  localparam int unsigned DEF_CLK_PER_FRAME  = 833334;
  localparam int unsigned DEF_FRAMES_PER_SEC = 60;
  localparam int unsigned DEF_ROUNDS         = 3;
  localparam int unsigned DEF_ROUND_SECONDS  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_PAUSED,
    ST_OVER
  } state_e;

  // Bits needed to hold 0..max_val (at least one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/round_sequencer_frame_tick_gen.sv
// Frame divider: counts 0..CLK_PER_FRAME while enabled, pulses tick_o on the
// cycle the count sits at CLK_PER_FRAME, and clears whenever disabled.
module frame_tick_gen
  import round_sequencer_pkg::*;
#(
  parameter int unsigned CLK_PER_FRAME = DEF_CLK_PER_FRAME
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned    CNT_W   = cnt_width(CLK_PER_FRAME);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_FRAME);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered from the look-ahead count so it lines up with cnt_q.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (enable_i) begin
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      tick_d = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller driving the round timer's enable; optional watchdog
// enabled by defining ROUND_SEQ_WATCHDOG_EN.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int unsigned CLK_PER_FRAME  = DEF_CLK_PER_FRAME,
  parameter int unsigned FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int unsigned ROUNDS         = DEF_ROUNDS,
  parameter int unsigned ROUND_SECONDS  = DEF_ROUND_SECONDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               timer_done,
  output logic               enable_timer,
  output logic [ROUND_W-1:0] round,
  output logic [SEC_W-1:0]   seconds_left,
  output logic               round_start,
  output logic               busy,
  output logic               game_over,
  output logic               timeout_err
);

  localparam int unsigned      FRAME_W   = cnt_width(FRAMES_PER_SEC - 1);
  localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(FRAMES_PER_SEC - 1);
  localparam logic [ROUND_W-1:0] LAST_RND  = ROUND_W'(ROUNDS - 1);

  state_e               state_q, state_d;
  logic                 gap_q, gap_d;
  logic                 adv_q, adv_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [SEC_W-1:0]     sec_q, sec_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 enable_q, enable_d;
  logic                 rs_q, rs_d;
  logic                 busy_q, busy_d;
  logic                 over_q, over_d;
  logic                 frame_tick;
  logic                 second_c;
  logic                 wd_fire_c;

  frame_tick_gen #(
    .CLK_PER_FRAME(CLK_PER_FRAME)
  ) u_frame_tick (
    .clk     (clk),
    .reset   (reset),
    .enable_i(state_q == ST_RUN),
    .tick_o  (frame_tick)
  );

  assign second_c = (state_q == ST_RUN) && frame_tick && (frame_q == FRAME_MAX);

`ifdef ROUND_SEQ_WATCHDOG_EN
  logic to_q;

  // A full second spent at zero without timer_done means the timer is stuck.
  assign wd_fire_c = second_c && (sec_q == '0) && !timer_done;

  always_ff @(posedge clk) begin
    if (reset)          to_q <= 1'b0;
    else if (wd_fire_c) to_q <= 1'b1;
  end

  assign timeout_err = to_q;
`else
  assign wd_fire_c   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    adv_d   = adv_q;
    round_d = round_q;
    sec_d   = sec_q;
    frame_d = frame_q;
    rs_d    = 1'b0;

    if ((state_q == ST_RUN) && frame_tick)
      frame_d = (frame_q == FRAME_MAX) ? '0 : frame_q + FRAME_W'(1);

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_GAP;
          gap_d   = 1'b0;
          round_d = '0;
          adv_d   = 1'b0;
        end
      end
      // Two-cycle gap lets the timer's stale done level drain.
      ST_GAP: begin
        if (gap_q) begin
          state_d = ST_RUN;
          if (adv_q) round_d = round_q + ROUND_W'(1);
          sec_d   = SEC_W'(ROUND_SECONDS);
          frame_d = '0;
          rs_d    = 1'b1;
        end else begin
          gap_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (timer_done || wd_fire_c) begin
          if (round_q == LAST_RND) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_GAP;
            gap_d   = 1'b0;
            adv_d   = 1'b1;
          end
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (second_c && (sec_q != '0)) begin
          sec_d = sec_q - SEC_W'(1);
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_d = ST_GAP;
          gap_d   = 1'b0;
          adv_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enable_d = (state_d == ST_RUN);
    busy_d   = (state_d == ST_RUN) || (state_d == ST_GAP) || (state_d == ST_PAUSED);
    over_d   = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gap_q    <= 1'b0;
      adv_q    <= 1'b0;
      round_q  <= '0;
      sec_q    <= '0;
      frame_q  <= '0;
      enable_q <= 1'b0;
      rs_q     <= 1'b0;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      adv_q    <= adv_d;
      round_q  <= round_d;
      sec_q    <= sec_d;
      frame_q  <= frame_d;
      enable_q <= enable_d;
      rs_q     <= rs_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
    end
  end

  assign enable_timer = enable_q;
  assign round        = round_q;
  assign seconds_left = sec_q;
  assign round_start  = rs_q;
  assign busy         = busy_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed plus randomized bench for round_sequencer against a cycle-count
// reference model of the round rules.
module tb_round_sequencer;

  localparam int CPF      = 3;
  localparam int FPS      = 2;
  localparam int NR       = 2;
  localparam int RS       = 5;
  localparam int SEC_CLKS = (CPF + 1) * FPS;
`ifdef ROUND_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam int M_IDLE = 0, M_GAP = 1, M_RUN = 2, M_PAUSED = 3, M_OVER = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       timer_done = 1'b0;
  logic       enable_timer;
  logic [2:0] round;
  logic [3:0] seconds_left;
  logic       round_start;
  logic       busy;
  logic       game_over;
  logic       timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: phase plus elapsed-clock arithmetic.
  int mode = M_IDLE, gap_left = 0, run_clk = 0, m_round = 0, m_sec = 0;
  bit m_adv = 1'b0, m_rs = 1'b0, m_to = 1'b0;

  round_sequencer #(
    .CLK_PER_FRAME (CPF),
    .FRAMES_PER_SEC(FPS),
    .ROUNDS        (NR),
    .ROUND_SECONDS (RS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .timer_done  (timer_done),
    .enable_timer(enable_timer),
    .round       (round),
    .seconds_left(seconds_left),
    .round_start (round_start),
    .busy        (busy),
    .game_over   (game_over),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit wd;
    m_rs = 1'b0;
    if (reset) begin
      mode = M_IDLE; m_round = 0; m_sec = 0; m_to = 1'b0; m_adv = 1'b0;
      gap_left = 0; run_clk = 0;
    end else begin
      case (mode)
        M_IDLE, M_OVER: if (start) begin
          mode = M_GAP; gap_left = 2; m_round = 0; m_adv = 1'b0;
        end
        M_GAP: begin
          gap_left--;
          if (gap_left == 0) begin
            mode = M_RUN;
            if (m_adv) m_round++;
            m_sec = RS; run_clk = 0; m_rs = 1'b1;
          end
        end
        M_RUN: begin
          wd = WD && (run_clk + 1 == (RS + 1) * SEC_CLKS) && !timer_done;
          if (timer_done || wd) begin
            if (wd) m_to = 1'b1;
            if (m_round == NR - 1) mode = M_OVER;
            else begin mode = M_GAP; gap_left = 2; m_adv = 1'b1; end
          end else if (pause) begin
            mode = M_PAUSED;
          end else begin
            run_clk++;
            m_sec = (run_clk / SEC_CLKS >= RS) ? 0 : RS - run_clk / SEC_CLKS;
          end
        end
        M_PAUSED: if (!pause) begin
          mode = M_GAP; gap_left = 2; m_adv = 1'b0;
        end
        default: mode = M_IDLE;
      endcase
    end
  endtask

  task automatic check_model();
    chk("enable_timer", 8'(enable_timer), 8'(mode == M_RUN));
    chk("round_start", 8'(round_start), 8'(m_rs));
    chk("round", 8'(round), 8'(m_round));
    chk("seconds_left", 8'(seconds_left), 8'(m_sec));
    chk("busy", 8'(busy), 8'(mode == M_GAP || mode == M_RUN || mode == M_PAUSED));
    chk("game_over", 8'(game_over), 8'(mode == M_OVER));
    chk("timeout_err", 8'(timeout_err), 8'(m_to));
  endtask

  // One clock: advance model on the edge, compare 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    // 1: reset, idle, start
    reset = 1'b1; repeat (3) cyc();
    reset = 1'b0; repeat (20) cyc();
    chk("idle_enable", 8'(enable_timer), 8'd0);
    chk("idle_busy", 8'(busy), 8'd0);
    chk("idle_seconds", 8'(seconds_left), 8'd0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_gap0_enable", 8'(enable_timer), 8'd0);
    cyc();
    chk("start_gap1_enable", 8'(enable_timer), 8'd0);
    cyc();
    chk("r0_enable", 8'(enable_timer), 8'd1);
    chk("r0_round_start", 8'(round_start), 8'd1);
    chk("r0_round", 8'(round), 8'd0);
    chk("r0_seconds", 8'(seconds_left), 8'd5);

    // 2: round 0 expiry with done lingering through the gap
    repeat (10) cyc();
    chk("r0_seconds_after_10", 8'(seconds_left), 8'd4);
    timer_done = 1'b1;
    cyc(); chk("done_gap0_enable", 8'(enable_timer), 8'd0);
    cyc(); chk("done_gap1_enable", 8'(enable_timer), 8'd0);
    cyc(); timer_done = 1'b0;
    chk("r1_enable", 8'(enable_timer), 8'd1);
    chk("r1_round_start", 8'(round_start), 8'd1);
    chk("r1_round", 8'(round), 8'd1);
    repeat (5) cyc();
    chk("r1_still_running", 8'(enable_timer), 8'd1);

    // 3: last round ends the game; start restarts
    timer_done = 1'b1; cyc(); timer_done = 1'b0;
    chk("over_flag", 8'(game_over), 8'd1);
    chk("over_busy", 8'(busy), 8'd0);
    chk("over_round", 8'(round), 8'd1);
    repeat (3) cyc();
    chk("over_hold", 8'(game_over), 8'd1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_busy", 8'(busy), 8'd1);
    chk("restart_round", 8'(round), 8'd0);
    chk("restart_over_clr", 8'(game_over), 8'd0);
    cyc(); cyc();
    chk("restart_rs", 8'(round_start), 8'd1);

    // 4: pause restarts the same round
    repeat (5) cyc();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("paused_enable", 8'(enable_timer), 8'd0);
    end
    pause = 1'b0;
    cyc(); chk("unpause_gap0", 8'(enable_timer), 8'd0);
    cyc(); chk("unpause_gap1", 8'(enable_timer), 8'd0);
    cyc();
    chk("unpause_rs", 8'(round_start), 8'd1);
    chk("unpause_round", 8'(round), 8'd0);
    chk("unpause_seconds", 8'(seconds_left), 8'd5);

    // 5: pause and done together -> done wins
    repeat (3) cyc();
    pause = 1'b1; timer_done = 1'b1; cyc(); pause = 1'b0; timer_done = 1'b0;
    chk("tie_busy", 8'(busy), 8'd1);
    cyc(); cyc();
    chk("tie_rs", 8'(round_start), 8'd1);
    chk("tie_round", 8'(round), 8'd1);
    timer_done = 1'b1; cyc(); timer_done = 1'b0;
    chk("tie_over", 8'(game_over), 8'd1);

    // 6: timer never finishes
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    repeat (40) cyc();
    chk("wd_seconds_zero", 8'(seconds_left), 8'd0);
    chk("wd_still_run", 8'(enable_timer), 8'd1);
    repeat (7) cyc();
    chk("wd_not_yet", 8'(timeout_err), 8'd0);
    cyc();
`ifdef ROUND_SEQ_WATCHDOG_EN
    chk("wd_fired", 8'(timeout_err), 8'd1);
    chk("wd_exit_enable", 8'(enable_timer), 8'd0);
    cyc(); cyc();
    chk("wd_next_round", 8'(round), 8'd1);
    chk("wd_next_rs", 8'(round_start), 8'd1);
`else
    chk("nowd_timeout", 8'(timeout_err), 8'd0);
    chk("nowd_running", 8'(enable_timer), 8'd1);
    repeat (20) cyc();
    chk("nowd_still_running", 8'(enable_timer), 8'd1);
`endif

    // 7: randomized traffic against the model
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(299) == 0);
      start      = ($urandom_range(5) == 0);
      pause      = ($urandom_range(11) == 0) ? ~pause : pause;
      timer_done = ($urandom_range(39) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
